// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, coin and inventory bundle for the change dispenser.
// master drives i_* (request, amount, refill); slave drives o_* (status, coin, counts).
interface change_dispenser_if;
  logic        i_req;
  logic [31:0] i_amount;
  logic [2:0]  i_load_coin;
  logic        o_busy;
  logic        o_coin_valid;
  logic [2:0]  o_coin;
  logic        o_done;
  logic [31:0] o_remainder;
  logic [7:0]  o_inv_100;
  logic [7:0]  o_inv_500;
  logic [7:0]  o_inv_1000;

  modport master (
    output i_req, i_amount, i_load_coin,
    input  o_busy, o_coin_valid, o_coin,
    input  o_done, o_remainder,
    input  o_inv_100, o_inv_500, o_inv_1000
  );

  modport slave (
    input  i_req, i_amount, i_load_coin,
    output o_busy, o_coin_valid, o_coin,
    output o_done, o_remainder,
    output o_inv_100, o_inv_500, o_inv_1000
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 1000/500/100 won coin dispenser with refillable stock.
// Ports: clk, reset (async, active-high), bus (change_dispenser_if.slave).
module change_dispenser #(
  parameter int unsigned INV_INIT = 8,
  parameter int unsigned INV_MAX  = 255
) (
  input  logic              clk,
  input  logic              reset,
  change_dispenser_if.slave bus
);

  localparam logic [7:0] INIT8 = 8'(INV_INIT);
  localparam logic [7:0] MAX8  = 8'(INV_MAX);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     remainder_q, remainder_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [2:0]      coin_q, coin_d;
  logic            done_q, done_d;
  logic [2:0][7:0] inv_q, inv_d;

  logic [2:0]      sel;
  logic [31:0]     sel_value;
  logic [2:0]      dec;
  logic [2:0]      inc;

  // Selection looks at pre-refill stock so a same-edge
  // refill can never enable a coin that is not there.
  always_comb begin
    sel       = 3'b000;
    sel_value = 32'd0;
    case (1'b1)
      (rem_q >= 32'd1000) && (inv_q[2] != 8'd0): begin
        sel       = 3'b100;
        sel_value = 32'd1000;
      end
      (rem_q >= 32'd500) && (inv_q[1] != 8'd0): begin
        sel       = 3'b010;
        sel_value = 32'd500;
      end
      (rem_q >= 32'd100) && (inv_q[0] != 8'd0): begin
        sel       = 3'b001;
        sel_value = 32'd100;
      end
      default: begin
        sel       = 3'b000;
        sel_value = 32'd0;
      end
    endcase
  end

  assign dec = (state_q == EMIT) ? sel : 3'b000;

  // A refill on a full counter still counts when the
  // same coin leaves, so the pair nets to zero.
  always_comb begin
    inc   = 3'b000;
    inv_d = inv_q;
    for (int k = 0; k < 3; k++) begin
      inc[k] = bus.i_load_coin[k] &&
               ((inv_q[k] != MAX8) || dec[k]);
      inv_d[k] = inv_q[k]
               + {7'd0, inc[k]}
               - {7'd0, dec[k]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req) state_d = EMIT;
      end
      EMIT: begin
        if (sel == 3'b000) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rem_d       = rem_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    coin_d      = 3'b000;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          rem_d  = bus.i_amount;
          busy_d = 1'b1;
        end
      end
      EMIT: begin
        if (sel != 3'b000) begin
          valid_d = 1'b1;
          coin_d  = sel;
          rem_d   = rem_q - sel_value;
        end else begin
          done_d      = 1'b1;
          remainder_d = rem_q;
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q       <= 32'd0;
      remainder_q <= 32'd0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      coin_q      <= 3'b000;
      done_q      <= 1'b0;
      inv_q       <= {3{INIT8}};
    end else begin
      rem_q       <= rem_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      coin_q      <= coin_d;
      done_q      <= done_d;
      inv_q       <= inv_d;
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_coin_valid = valid_q;
  assign bus.o_coin       = coin_q;
  assign bus.o_done       = done_q;
  assign bus.o_remainder  = remainder_q;
  assign bus.o_inv_100    = inv_q[0];
  assign bus.o_inv_500    = inv_q[1];
  assign bus.o_inv_1000   = inv_q[2];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scenarios for change_dispenser.
// Each task drives one scenario and checks hand-computed values.
module tb_change_dispenser;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  change_dispenser_if dif ();

  change_dispenser #(
    .INV_INIT(8),
    .INV_MAX (255)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic start(input logic [31:0] amt);
    dif.i_req    = 1'b1;
    dif.i_amount = amt;
    tick();
    dif.i_req    = 1'b0;
    dif.i_amount = 32'd0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) tick();
    n_chk++;
    if ({dif.o_busy, dif.o_coin_valid,
         dif.o_coin, dif.o_done} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=0",
        {dif.o_busy, dif.o_coin_valid,
         dif.o_coin, dif.o_done});
    end
    n_chk++;
    if (dif.o_remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rem got=%0d want=0",
        dif.o_remainder);
    end
    n_chk++;
    if ({dif.o_inv_100, dif.o_inv_500,
         dif.o_inv_1000} !== {8'd8, 8'd8, 8'd8}) begin
      n_fail++;
      $display("FAIL reset_inv got=%0d/%0d/%0d want=8/8/8",
        dif.o_inv_100, dif.o_inv_500, dif.o_inv_1000);
    end
  endtask

  task automatic test_1700();
    logic [2:0] exp [4];
    exp = '{3'b100, 3'b010, 3'b001, 3'b001};
    start(32'd1700);
    n_chk++;
    if (dif.o_busy !== 1'b1 || dif.o_coin_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL 1700_capture busy=%b valid=%b want 1/0",
        dif.o_busy, dif.o_coin_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (dif.o_coin_valid !== 1'b1 || dif.o_coin !== exp[i]) begin
        n_fail++;
        $display("FAIL 1700_coin%0d got=%b/%b want=1/%b",
          i, dif.o_coin_valid, dif.o_coin, exp[i]);
      end
    end
    tick();
    n_chk++;
    if (dif.o_done !== 1'b1 || dif.o_remainder !== 32'd0 ||
        dif.o_coin_valid !== 1'b0 || dif.o_coin !== 3'b000 ||
        dif.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL 1700_done done=%b rem=%0d v=%b c=%b b=%b want 1/0/0/0/1",
        dif.o_done, dif.o_remainder, dif.o_coin_valid,
        dif.o_coin, dif.o_busy);
    end
    tick();
    n_chk++;
    if (dif.o_done !== 1'b0 || dif.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL 1700_idle done=%b busy=%b want 0/0",
        dif.o_done, dif.o_busy);
    end
    n_chk++;
    if ({dif.o_inv_100, dif.o_inv_500,
         dif.o_inv_1000} !== {8'd6, 8'd7, 8'd7}) begin
      n_fail++;
      $display("FAIL 1700_inv got=%0d/%0d/%0d want=6/7/7",
        dif.o_inv_100, dif.o_inv_500, dif.o_inv_1000);
    end
  endtask

  task automatic test_zero();
    start(32'd0);
    tick();
    n_chk++;
    if (dif.o_done !== 1'b1 || dif.o_coin_valid !== 1'b0 ||
        dif.o_remainder !== 32'd0 || dif.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done done=%b v=%b rem=%0d b=%b want 1/0/0/1",
        dif.o_done, dif.o_coin_valid,
        dif.o_remainder, dif.o_busy);
    end
    tick();
    n_chk++;
    if (dif.o_busy !== 1'b0 || dif.o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle busy=%b done=%b want 0/0",
        dif.o_busy, dif.o_done);
    end
  endtask

  task automatic test_13000();
    logic [2:0] exp;
    do_reset();
    start(32'd13000);
    for (int i = 0; i < 24; i++) begin
      exp = (i < 8) ? 3'b100 : (i < 16) ? 3'b010 : 3'b001;
      tick();
      n_chk++;
      if (dif.o_coin_valid !== 1'b1 || dif.o_coin !== exp) begin
        n_fail++;
        $display("FAIL 13000_coin%0d got=%b/%b want=1/%b",
          i, dif.o_coin_valid, dif.o_coin, exp);
      end
    end
    tick();
    n_chk++;
    if (dif.o_done !== 1'b1 || dif.o_remainder !== 32'd200) begin
      n_fail++;
      $display("FAIL 13000_done done=%b rem=%0d want 1/200",
        dif.o_done, dif.o_remainder);
    end
    n_chk++;
    if ({dif.o_inv_100, dif.o_inv_500,
         dif.o_inv_1000} !== 24'd0) begin
      n_fail++;
      $display("FAIL 13000_inv got=%0d/%0d/%0d want=0/0/0",
        dif.o_inv_100, dif.o_inv_500, dif.o_inv_1000);
    end
    tick();
  endtask

  task automatic test_250_ignore();
    do_reset();
    start(32'd250);
    dif.i_req    = 1'b1;
    dif.i_amount = 32'd1000;
    tick();
    dif.i_req    = 1'b0;
    dif.i_amount = 32'd0;
    n_chk++;
    if (dif.o_coin_valid !== 1'b1 || dif.o_coin !== 3'b001) begin
      n_fail++;
      $display("FAIL 250_coin0 got=%b/%b want=1/001",
        dif.o_coin_valid, dif.o_coin);
    end
    tick();
    n_chk++;
    if (dif.o_coin_valid !== 1'b1 || dif.o_coin !== 3'b001) begin
      n_fail++;
      $display("FAIL 250_coin1 got=%b/%b want=1/001",
        dif.o_coin_valid, dif.o_coin);
    end
    tick();
    n_chk++;
    if (dif.o_done !== 1'b1 || dif.o_remainder !== 32'd50) begin
      n_fail++;
      $display("FAIL 250_done done=%b rem=%0d want 1/50",
        dif.o_done, dif.o_remainder);
    end
    tick();
    tick();
    n_chk++;
    if (dif.o_busy !== 1'b0 || dif.o_coin_valid !== 1'b0 ||
        dif.o_inv_1000 !== 8'd8) begin
      n_fail++;
      $display("FAIL 250_noqueue busy=%b v=%b inv1000=%0d want 0/0/8",
        dif.o_busy, dif.o_coin_valid, dif.o_inv_1000);
    end
  endtask

  task automatic test_refill();
    do_reset();
    start(32'd1700);
    dif.i_load_coin = 3'b001;
    tick();
    tick();
    n_chk++;
    if (dif.o_inv_100 !== 8'd10) begin
      n_fail++;
      $display("FAIL refill_mid got=%0d want=10",
        dif.o_inv_100);
    end
    tick();
    n_chk++;
    if (dif.o_inv_100 !== 8'd10 || dif.o_coin !== 3'b001) begin
      n_fail++;
      $display("FAIL refill_same inv=%0d coin=%b want 10/001",
        dif.o_inv_100, dif.o_coin);
    end
    tick();
    tick();
    dif.i_load_coin = 3'b000;
    n_chk++;
    if (dif.o_done !== 1'b1 || dif.o_remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL refill_done done=%b rem=%0d want 1/0",
        dif.o_done, dif.o_remainder);
    end
    tick();
    n_chk++;
    if (dif.o_inv_100 !== 8'd11) begin
      n_fail++;
      $display("FAIL refill_end got=%0d want=11",
        dif.o_inv_100);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    dif.i_load_coin = 3'b111;
    repeat (250) tick();
    dif.i_load_coin = 3'b000;
    n_chk++;
    if ({dif.o_inv_100, dif.o_inv_500,
         dif.o_inv_1000} !== {8'd255, 8'd255, 8'd255}) begin
      n_fail++;
      $display("FAIL sat_inv got=%0d/%0d/%0d want=255 each",
        dif.o_inv_100, dif.o_inv_500, dif.o_inv_1000);
    end
  endtask

  task automatic test_abort_reset();
    logic saw_done;
    do_reset();
    start(32'd1700);
    tick();
    n_chk++;
    if (dif.o_coin !== 3'b100 || dif.o_inv_1000 !== 8'd7) begin
      n_fail++;
      $display("FAIL abort_pre coin=%b inv1000=%0d want 100/7",
        dif.o_coin, dif.o_inv_1000);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({dif.o_busy, dif.o_coin_valid, dif.o_coin,
         dif.o_done} !== 6'd0 ||
        dif.o_remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_clear flags=%b rem=%0d want 0/0",
        {dif.o_busy, dif.o_coin_valid, dif.o_coin,
         dif.o_done}, dif.o_remainder);
    end
    n_chk++;
    if ({dif.o_inv_100, dif.o_inv_500,
         dif.o_inv_1000} !== {8'd8, 8'd8, 8'd8}) begin
      n_fail++;
      $display("FAIL abort_inv got=%0d/%0d/%0d want=8/8/8",
        dif.o_inv_100, dif.o_inv_500, dif.o_inv_1000);
    end
    tick();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dif.o_done !== 1'b0 || dif.o_busy !== 1'b0)
        saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_nodone got=%b want=0", saw_done);
    end
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    reset           = 1'b1;
    dif.i_req       = 1'b0;
    dif.i_amount    = 32'd0;
    dif.i_load_coin = 3'b000;
    #2;
    test_reset();
    test_1700();
    test_zero();
    test_13000();
    test_250_ignore();
    test_refill();
    test_saturate();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter INV_INIT, default 8, coin count loaded into each inventory at reset.
REQ-002 Parameter INV_MAX, default 255, inventory saturation limit; inventory counters are 8 bits.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port i_req  input  1  start-dispense request, sampled in IDLE only.
REQ-006 Port i_amount  input  32  amount to return in won, captured with i_req.
REQ-007 Port i_load_coin  input  3  per-cycle refill; bit0=100, bit1=500, bit2=1000; each set bit adds one coin.
REQ-008 Port o_busy  output  1  high from the cycle after request capture through the DONE cycle.
REQ-009 Port o_coin_valid  output  1  one coin issued this cycle.
REQ-010 Port o_coin  output  3  one-hot coin type (same encoding as i_load_coin); 0 when o_coin_valid=0.
REQ-011 Port o_done  output  1  one-cycle completion pulse.
REQ-012 Port o_remainder  output  32  undispensed amount, valid while o_done=1, held until next capture.
REQ-013 Ports o_inv_100, o_inv_500, o_inv_1000  output  8 each  current inventory counts.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have states IDLE, EMIT, DONE.
REQ-016 IDLE: on an edge with i_req=1, latch i_amount into the 32-bit rem register, set o_busy=1, go to EMIT; i_req=0 stays IDLE.
REQ-017 EMIT, each edge: select the largest coin with value <= rem and inventory > 0 (priority 1000, 500, 100).
REQ-018 EMIT with a selectable coin: o_coin_valid<=1, o_coin<=selected type, rem<=rem-value, that inventory<=inventory-1; stay in EMIT.
REQ-019 EMIT with no selectable coin (including rem=0): o_coin_valid<=0, o_coin<=0, o_done<=1, o_remainder<=rem, go to DONE.
REQ-020 DONE, next edge: o_done<=0, o_busy<=0, go to IDLE.
REQ-021 Latency: capture edge E0; first coin visible after E1; after the last coin edge En, o_done is visible after En+1 and o_busy drops after En+2.
REQ-022 i_req SHALL be ignored in EMIT and DONE; no queuing.
REQ-023 Amounts not a multiple of 100 SHALL be dispensed greedily, with the sub-100 residue reported in o_remainder.
REQ-024 i_load_coin SHALL be honoured in every state; an inventory at INV_MAX SHALL not increment.
REQ-025 Refill and dispense of the same type on one edge SHALL leave that inventory unchanged, with the coin still issued.
REQ-026 Coin selection on an edge SHALL use inventory values from before that edge's refill.

Reset
REQ-027 On reset assertion, immediately: state=IDLE, rem=0, o_busy=0, o_coin_valid=0, o_coin=0, o_done=0, o_remainder=0, all inventories=INV_INIT.
REQ-028 Reset during EMIT or DONE SHALL abort the dispense with no o_done pulse, and SHALL restore inventories to INV_INIT.

Verification
REQ-029 Reset, then idle for 3 cycles -> all outputs 0; o_inv_100 = o_inv_500 = o_inv_1000 = 8.
REQ-030 i_req with i_amount=1700 -> coins 1000, 500, 100, 100 on 4 consecutive cycles; then o_done=1 with o_remainder=0; inventories 6/7/7 (100/500/1000).
REQ-031 i_amount=0 -> no coin; o_done visible after E1; o_remainder=0; o_busy low after E2.
REQ-032 i_amount=13000 from reset -> 8x1000, 8x500, 8x100 (24 coins); o_remainder=200; all inventories 0.
REQ-033 i_amount=250 -> 100, 100; o_remainder=50. A second i_req asserted during EMIT is ignored.
REQ-034 i_load_coin=3'b001 held during a 1700 dispense -> o_inv_100 ends at 8+5-2=11. Reset asserted mid-EMIT -> outputs clear at once, inventories return to 8, and no o_done pulse occurs.
